// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI mode-0 slave byte engine.
package spi_slave_pkg;

  localparam int SPI_DATA_W      = 8;
  localparam int SPI_SYNC_STAGES = 2;

  // Word shifted out when a word starts with nothing in the holding register.
  localparam logic [7:0] SPI_IDLE_FILL = 8'h00;

endpackage

// File: rtl/spi_slave_core_if.sv
// Byte-side bus of the SPI slave core: received-word strobe and TX holding register.
interface spi_slave_core_if #(
  parameter int DATA_W = 8
) ();

  // TX handshake: a word transfers on any clk edge where tx_valid_i && tx_ready_o;
  // tx_data_i must be stable while tx_valid_i is high. RX has no backpressure:
  // rx_valid_o is a 1-clk strobe and rx_data_o holds until the next word completes.
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_valid_i;
  logic              tx_ready_o;
  logic              tx_underrun_o;

  modport slave (
    output rx_data_o, rx_valid_o, tx_ready_o, tx_underrun_o,
    input  tx_data_i, tx_valid_i
  );

  modport master (
    input  rx_data_o, rx_valid_o, tx_ready_o, tx_underrun_o,
    output tx_data_i, tx_valid_i
  );

endinterface

// File: rtl/spi_sync_edge.sv
// N-flop synchronizer for an asynchronous pin plus one history flop for edge detection.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Flops reset to 0 so a pin already low at reset release never produces a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave byte engine, MSB first, fully oversampled in the clk domain.
module spi_slave_core
  import spi_slave_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_sclk_i,
  input  logic             spi_cs_n_i,
  input  logic             spi_mosi_i,
  output logic             spi_miso_o,
  output logic             spi_miso_oe_o,
  output logic             frame_active_o,
  spi_slave_core_if.slave  bus
);

  localparam int                CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] IDLE_WORD = DATA_W'(SPI_IDLE_FILL);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic sync_unused;

  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_bit;

  logic              active_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] tx_buf;
  logic              tx_pend;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              underrun_q;

  logic shift_en, word_start, consume, write_en, miso_bit;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi_sclk_i),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi_cs_n_i),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  assign sync_unused = ^{sclk_lvl, sclk_fall, cs_lvl};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_q <= '0;
    end else begin
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi_i};
    end
  end

  assign mosi_bit = mosi_q[SYNC_STAGES-1];

  // A frame only counts once its CS fall was seen after reset, so a frame
  // already running when reset releases stays ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
    end else if (cs_fall) begin
      active_q <= 1'b1;
    end else if (cs_rise) begin
      active_q <= 1'b0;
    end
  end

  assign frame_active_o = (active_q & ~cs_rise) | cs_fall;
  assign spi_miso_oe_o  = frame_active_o;

  assign shift_en   = sclk_rise & frame_active_o & ~cs_fall;
  assign word_start = shift_en & (bit_cnt == '0);
  assign consume    = word_start & tx_pend;
  assign write_en   = bus.tx_valid_i & bus.tx_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      if (cs_fall || cs_rise) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
        tx_sr   <= '0;
      end else if (shift_en) begin
        rx_sr   <= {rx_sr[DATA_W-2:0], mosi_bit};
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        if (bit_cnt == '0) begin
          if (tx_pend) begin
            tx_sr <= tx_buf << 1;
          end else begin
            tx_sr      <= IDLE_WORD << 1;
            underrun_q <= 1'b1;
          end
        end else begin
          tx_sr <= tx_sr << 1;
        end
        if (bit_cnt == LAST_BIT) begin
          rx_data_q  <= {rx_sr[DATA_W-2:0], mosi_bit};
          rx_valid_q <= 1'b1;
        end
      end
    end
  end

  // Consumption is applied before the write so a same-cycle write is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf  <= '0;
      tx_pend <= 1'b0;
    end else begin
      if (consume) begin
        tx_pend <= 1'b0;
      end
      if (write_en) begin
        tx_buf  <= bus.tx_data_i;
        tx_pend <= 1'b1;
      end
    end
  end

  // Before the first rise of a word the MSB comes straight from the holding register.
  always_comb begin
    miso_bit = tx_sr[DATA_W-1];
    if (bit_cnt == '0) begin
      miso_bit = tx_pend ? tx_buf[DATA_W-1] : IDLE_WORD[DATA_W-1];
    end
    spi_miso_o = frame_active_o & miso_bit;
  end

  assign bus.rx_data_o     = rx_data_q;
  assign bus.rx_valid_o    = rx_valid_q;
  assign bus.tx_ready_o    = ~tx_pend;
  assign bus.tx_underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: SPI master driver, TX writer, RX/underrun scoreboard.
module tb_spi_slave_core;
  import spi_slave_pkg::*;

  localparam int W        = SPI_DATA_W;
  localparam int HALF_CLK = 13;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sclk  = 1'b0;
  logic cs_n  = 1'b1;
  logic mosi  = 1'b0;
  logic miso, miso_oe, frame_active;

  spi_slave_core_if #(.DATA_W(W)) bus ();

  spi_slave_core #(.DATA_W(W), .SYNC_STAGES(SPI_SYNC_STAGES)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .spi_sclk_i     (sclk),
    .spi_cs_n_i     (cs_n),
    .spi_mosi_i     (mosi),
    .spi_miso_o     (miso),
    .spi_miso_oe_o  (miso_oe),
    .frame_active_o (frame_active),
    .bus            (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #10 clk = ~clk;

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state and reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_rx_q[$];
  int exp_under = 0;
  int got_under = 0;
  bit           m_held = 1'b0;
  logic [W-1:0] m_val  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected RX words on each strobe and counts underrun strobes.
  always @(negedge clk) begin
    if (rst_n && bus.rx_valid_o) begin
      if (exp_rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got word %0h with no word expected", bus.rx_data_o);
      end else begin
        chk("rx_data", bus.rx_data_o, exp_rx_q.pop_front());
      end
    end
    if (rst_n && bus.tx_underrun_o) got_under++;
  end

  // ---------------- driver tasks ----------------
  task automatic half_phase();
    repeat (HALF_CLK) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_frame_active"}, frame_active, 0);
    chk({tag, "_miso_oe"}, miso_oe, 0);
    chk({tag, "_miso"}, miso, 0);
    chk({tag, "_rx_valid"}, bus.rx_valid_o, 0);
    chk({tag, "_underrun"}, bus.tx_underrun_o, 0);
    chk({tag, "_tx_ready"}, bus.tx_ready_o, 1);
  endtask

  task automatic tx_write(input logic [W-1:0] d);
    int n;
    @(negedge clk);
    bus.tx_data_i  = d;
    bus.tx_valid_i = 1'b1;
    n = 0;
    while (!bus.tx_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_ready_o) chk("tx_write_timeout", bus.tx_ready_o, 1);
    else begin
      m_held = 1'b1;
      m_val  = d;
    end
    @(posedge clk);
    #1;
    bus.tx_valid_i = 1'b0;
  endtask

  // One word (or the first nbits of it) as master; optionally writes the next TX word mid-word.
  task automatic spi_word(input logic [W-1:0] mo, input int nbits, input bit wr, input logic [W-1:0] wd);
    logic [W-1:0] exp_mi, got, ones, mask;
    if (m_held) begin
      exp_mi = m_val;
      m_held = 1'b0;
    end else begin
      exp_mi = W'(SPI_IDLE_FILL);
      exp_under++;
    end
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[W-1-i];
      half_phase();
      got[W-1-i] = miso;
      if (i == W-1) exp_rx_q.push_back(mo);
      sclk = 1'b1;
      if (i == 3) begin
        chk("miso_oe_active", miso_oe, 1);
        chk("tx_ready_after_rise", bus.tx_ready_o, {31'd0, !m_held});
        if (wr) tx_write(wd);
      end
      half_phase();
      sclk = 1'b0;
    end
    ones = '1;
    mask = ~(ones >> nbits);
    chk("miso_word", got & mask, exp_mi & mask);
  endtask

  task automatic frame_begin();
    @(negedge clk);
    cs_n = 1'b0;
    half_phase();
  endtask

  task automatic frame_end();
    half_phase();
    cs_n = 1'b1;
    half_phase();
    chk("underrun_count", got_under, exp_under);
    chk("oe_after_frame", miso_oe, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nw, nb;
    bit abort_f, wr;
    bus.tx_data_i  = '0;
    bus.tx_valid_i = 1'b0;

    // Reset held while the pins toggle.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      sclk = ~sclk;
      cs_n = ~cs_n;
      mosi = ~mosi;
      repeat (5) @(negedge clk);
    end
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    check_idle("in_reset");
    chk("rx_data_reset", bus.rx_data_o, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_idle("post_reset");

    // Single word.
    tx_write(8'hA5);
    frame_begin();
    spi_word(8'h3C, 8, 1'b0, '0);
    frame_end();

    // Two-word frame with the second TX word written during word 1.
    tx_write(8'h81);
    frame_begin();
    spi_word(8'h12, 8, 1'b1, 8'h7E);
    spi_word(8'h34, 8, 1'b0, '0);
    frame_end();

    // Underrun.
    frame_begin();
    spi_word(8'hC3, 8, 1'b0, '0);
    frame_end();

    // Abort after 5 bits, then a clean frame.
    frame_begin();
    spi_word(8'h6B, 5, 1'b0, '0);
    frame_end();
    frame_begin();
    spi_word(8'hFF, 8, 1'b0, '0);
    frame_end();

    // Asynchronous reset at bit 3 of a frame.
    tx_write(8'h96);
    frame_begin();
    spi_word(8'h00, 3, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #3;
    check_idle("async_rst");
    chk("rx_data_async_rst", bus.rx_data_o, 0);
    m_held = 1'b0;
    exp_under = 0;
    got_under = 0;
    exp_rx_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 3; i < W; i++) begin
      mosi = 1'b1;
      half_phase();
      chk("ignored_frame_oe", miso_oe, 0);
      sclk = 1'b1;
      half_phase();
      sclk = 1'b0;
    end
    half_phase();
    cs_n = 1'b1;
    half_phase();
    tx_write(8'h3F);
    frame_begin();
    spi_word(8'h5A, 8, 1'b0, '0);
    frame_end();

    // Randomized frames against the reference model.
    for (int f = 0; f < 20; f++) begin
      nw      = $urandom_range(1, 3);
      abort_f = ($urandom_range(0, 4) == 0);
      if (!m_held && $urandom_range(0, 1) == 1) tx_write(W'($urandom));
      frame_begin();
      for (int w = 0; w < nw; w++) begin
        nb = (abort_f && w == nw - 1) ? $urandom_range(1, 7) : 8;
        wr = (nb >= 4) && ($urandom_range(0, 3) != 0);
        spi_word(W'($urandom), nb, wr, W'($urandom));
      end
      frame_end();
    end

    repeat (50) @(negedge clk);
    chk("rx_queue_empty", exp_rx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
